// File: rtl/bc_pkg.sv
// ---------------------------------------------------------------------------
// bc_pkg
// Shared definitions for the Bulls-and-Cows datapath: digit geometry, the
// judge state encoding, the four-digit array type used between the input
// collector and the judge, and a helper that checks that a set of digits
// is a legal Bulls-and-Cows code (all decimal, no repeats).
// ---------------------------------------------------------------------------
package bc_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = 4;
   localparam int MAX_DIGIT  = 9;
   localparam int IDX_W      = 2;
   localparam logic [DIGIT_W-1:0] DIGIT_UNSET = 4'hF;

   typedef enum logic [2:0] {
      ST_NOSECRET,
      ST_IDLE,
      ST_VALIDATE,
      ST_SCAN,
      ST_REPORT,
      ST_WON,
      ST_LOST
   } state_t;

   // Element [0] is the first (leftmost) digit of the code.
   typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

   // A code is legal when every digit is 0..9 and no two digits repeat.
   function automatic logic digits_ok(input digits_t d);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (int'(d[i]) > MAX_DIGIT) ok = 1'b0;
         for (int j = i + 1; j < NUM_DIGITS; j++) begin
            if (d[i] == d[j]) ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/bc_digit_match.sv
// ---------------------------------------------------------------------------
// bc_digit_match
// Compares one guess digit against the whole secret. Purely combinational;
// the judge time-multiplexes a single instance across its scan cycles.
//   guess_digit in  4  guess digit at position idx
//   secret      in 16  the four latched secret digits
//   idx         in  2  position of guess_digit within the guess
//   bull        out 1  guess digit equals the secret digit at idx
//   cow         out 2  number of other secret positions holding this digit
// ---------------------------------------------------------------------------
module bc_digit_match
   import bc_pkg::*;
(
   input  logic [DIGIT_W-1:0] guess_digit,
   input  digits_t            secret,
   input  logic [IDX_W-1:0]   idx,
   output logic               bull,
   output logic [1:0]         cow
);

   always_comb begin
      bull = 1'b0;
      cow  = 2'd0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (guess_digit == secret[j]) begin
            if (idx == IDX_W'(j)) bull = 1'b1;
            else                  cow  = cow + 2'd1;
         end
      end
   end

endmodule

// File: rtl/bc_judge.sv
// ---------------------------------------------------------------------------
// bc_judge
// Scoring stage of Bulls-and-Cows. new_game latches and checks a secret;
// start snapshots the guess, which is validated in one cycle, scanned one
// position per cycle over four cycles, and reported with a done pulse.
// Attempts and the sticky win/lose outcome are tracked per game.
//   clk, rst_n           clock, async active-low reset
//   new_game, secret1..4 start a game with the given secret
//   start, guess1..4     score the guess (accepted only when idle)
//   busy, done           scan in progress / one-cycle result strobe
//   bulls, cows, invalid result of the last reported guess
//   tries, win, lose     per-game attempt count and outcome
// ---------------------------------------------------------------------------
module bc_judge
   import bc_pkg::*;
#(
   parameter int MAX_TRIES = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               new_game,
   input  logic [DIGIT_W-1:0] secret1,
   input  logic [DIGIT_W-1:0] secret2,
   input  logic [DIGIT_W-1:0] secret3,
   input  logic [DIGIT_W-1:0] secret4,
   input  logic               start,
   input  logic [DIGIT_W-1:0] guess1,
   input  logic [DIGIT_W-1:0] guess2,
   input  logic [DIGIT_W-1:0] guess3,
   input  logic [DIGIT_W-1:0] guess4,
   output logic               busy,
   output logic               done,
   output logic [2:0]         bulls,
   output logic [2:0]         cows,
   output logic               invalid,
   output logic [3:0]         tries,
   output logic               win,
   output logic               lose
);

   state_t           state_q, state_d;
   digits_t          secret_q, secret_d;
   digits_t          guess_q, guess_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [2:0]       bulls_acc_q, bulls_acc_d;
   logic [2:0]       cows_acc_q, cows_acc_d;
   logic             bad_q, bad_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [2:0]       bulls_q, bulls_d;
   logic [2:0]       cows_q, cows_d;
   logic             invalid_q, invalid_d;
   logic [3:0]       tries_q, tries_d;
   logic             win_q, win_d;
   logic             lose_q, lose_d;

   logic             bull_hit;
   logic [1:0]       cow_hits;
   logic [3:0]       tries_inc;
   digits_t          secret_in;
   digits_t          guess_in;

   assign secret_in = {secret4, secret3, secret2, secret1};
   assign guess_in  = {guess4, guess3, guess2, guess1};
   assign tries_inc = tries_q + 4'd1;

   bc_digit_match u_match (
      .guess_digit (guess_q[idx_q]),
      .secret      (secret_q),
      .idx         (idx_q),
      .bull        (bull_hit),
      .cow         (cow_hits)
   );

   // Next-state and next-output logic. new_game overrides everything,
   // including a start in the same cycle and any scan in flight.
   always_comb begin
      state_d     = state_q;
      secret_d    = secret_q;
      guess_d     = guess_q;
      idx_d       = idx_q;
      bulls_acc_d = bulls_acc_q;
      cows_acc_d  = cows_acc_q;
      bad_d       = bad_q;
      done_d      = 1'b0;
      bulls_d     = bulls_q;
      cows_d      = cows_q;
      invalid_d   = invalid_q;
      tries_d     = tries_q;
      win_d       = win_q;
      lose_d      = lose_q;

      if (new_game) begin
         secret_d  = secret_in;
         tries_d   = 4'd0;
         win_d     = 1'b0;
         lose_d    = 1'b0;
         bulls_d   = 3'd0;
         cows_d    = 3'd0;
         invalid_d = 1'b0;
         state_d   = digits_ok(secret_in) ? ST_IDLE : ST_NOSECRET;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  guess_d = guess_in;
                  state_d = ST_VALIDATE;
               end
            end
            ST_VALIDATE: begin
               if (!digits_ok(guess_q)) begin
                  bad_d   = 1'b1;
                  state_d = ST_REPORT;
               end else begin
                  bad_d       = 1'b0;
                  bulls_acc_d = 3'd0;
                  cows_acc_d  = 3'd0;
                  idx_d       = '0;
                  state_d     = ST_SCAN;
               end
            end
            ST_SCAN: begin
               bulls_acc_d = bulls_acc_q + {2'b00, bull_hit};
               cows_acc_d  = cows_acc_q + {1'b0, cow_hits};
               idx_d       = idx_q + 1'b1;
               if (idx_q == IDX_W'(NUM_DIGITS - 1)) state_d = ST_REPORT;
            end
            ST_REPORT: begin
               done_d    = 1'b1;
               invalid_d = bad_q;
               state_d   = ST_IDLE;
               if (bad_q) begin
                  bulls_d = 3'd0;
                  cows_d  = 3'd0;
               end else begin
                  bulls_d = bulls_acc_q;
                  cows_d  = cows_acc_q;
                  tries_d = tries_inc;
                  // A winning final attempt counts as a win, not a loss.
                  if (bulls_acc_q == 3'(NUM_DIGITS)) begin
                     win_d   = 1'b1;
                     state_d = ST_WON;
                  end else if (tries_inc == 4'(MAX_TRIES)) begin
                     lose_d  = 1'b1;
                     state_d = ST_LOST;
                  end
               end
            end
            default: ;
         endcase
      end

      // busy covers the scan and report cycles, not the validate cycle.
      busy_d = (state_d == ST_SCAN) || (state_d == ST_REPORT);
   end

   // All state and outputs are registered; reset clears to NOSECRET.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_NOSECRET;
         secret_q    <= '0;
         guess_q     <= '0;
         idx_q       <= '0;
         bulls_acc_q <= 3'd0;
         cows_acc_q  <= 3'd0;
         bad_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         bulls_q     <= 3'd0;
         cows_q      <= 3'd0;
         invalid_q   <= 1'b0;
         tries_q     <= 4'd0;
         win_q       <= 1'b0;
         lose_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         secret_q    <= secret_d;
         guess_q     <= guess_d;
         idx_q       <= idx_d;
         bulls_acc_q <= bulls_acc_d;
         cows_acc_q  <= cows_acc_d;
         bad_q       <= bad_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         bulls_q     <= bulls_d;
         cows_q      <= cows_d;
         invalid_q   <= invalid_d;
         tries_q     <= tries_d;
         win_q       <= win_d;
         lose_q      <= lose_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign bulls   = bulls_q;
   assign cows    = cows_q;
   assign invalid = invalid_q;
   assign tries   = tries_q;
   assign win     = win_q;
   assign lose    = lose_q;

endmodule

// File: tb/tb_bc_judge.sv
// ---------------------------------------------------------------------------
// tb_bc_judge
// Self-checking bench for bc_judge: a transaction-level game model scores
// each accepted guess arithmetically and predicts every output each cycle,
// alongside directed scenarios with literal expectations and a random phase.
// ---------------------------------------------------------------------------
module tb_bc_judge;

   localparam int MAX_TRIES = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       new_game = 1'b0;
   logic       start = 1'b0;
   logic [3:0] secret1 = 4'd0, secret2 = 4'd0, secret3 = 4'd0, secret4 = 4'd0;
   logic [3:0] guess1 = 4'hF, guess2 = 4'hF, guess3 = 4'hF, guess4 = 4'hF;
   logic       busy, done, invalid, win, lose;
   logic [2:0] bulls, cows;
   logic [3:0] tries;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bc_judge #(.MAX_TRIES(MAX_TRIES)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .new_game (new_game),
      .secret1  (secret1),
      .secret2  (secret2),
      .secret3  (secret3),
      .secret4  (secret4),
      .start    (start),
      .guess1   (guess1),
      .guess2   (guess2),
      .guess3   (guess3),
      .guess4   (guess4),
      .busy     (busy),
      .done     (done),
      .bulls    (bulls),
      .cows     (cows),
      .invalid  (invalid),
      .tries    (tries),
      .win      (win),
      .lose     (lose)
   );

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit code_ok(input int a, input int b, input int c, input int d);
      return (a <= 9) && (b <= 9) && (c <= 9) && (d <= 9) &&
             (a != b) && (a != c) && (a != d) && (b != c) && (b != d) && (c != d);
   endfunction

   // Game model: a countdown to the report edge stands in for the scan.
   int  m_secret[4];
   int  m_guess[4];
   bit  m_armed, m_over, m_bad;
   int  m_cnt, m_len, m_bulls, m_cows;
   bit  e_done, e_busy, e_invalid, e_win, e_lose;
   int  e_bulls, e_cows, e_tries;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_armed = 0; m_over = 0; m_cnt = 0; m_len = 0;
         e_done = 0; e_busy = 0; e_invalid = 0; e_win = 0; e_lose = 0;
         e_bulls = 0; e_cows = 0; e_tries = 0;
      end else begin
         e_done = 0;
         if (new_game) begin
            m_secret[0] = int'(secret1); m_secret[1] = int'(secret2);
            m_secret[2] = int'(secret3); m_secret[3] = int'(secret4);
            m_armed = code_ok(m_secret[0], m_secret[1], m_secret[2], m_secret[3]);
            m_over = 0; m_cnt = 0;
            e_invalid = 0; e_win = 0; e_lose = 0;
            e_bulls = 0; e_cows = 0; e_tries = 0;
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               e_done    = 1;
               e_invalid = m_bad;
               if (m_bad) begin
                  e_bulls = 0; e_cows = 0;
               end else begin
                  e_bulls = m_bulls; e_cows = m_cows;
                  e_tries++;
                  if (m_bulls == 4) begin
                     e_win = 1; m_over = 1;
                  end else if (e_tries == MAX_TRIES) begin
                     e_lose = 1; m_over = 1;
                  end
               end
            end
         end else if (start && m_armed && !m_over) begin
            m_guess[0] = int'(guess1); m_guess[1] = int'(guess2);
            m_guess[2] = int'(guess3); m_guess[3] = int'(guess4);
            m_bad   = !code_ok(m_guess[0], m_guess[1], m_guess[2], m_guess[3]);
            m_bulls = 0;
            m_cows  = 0;
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++)
                  if (m_guess[i] == m_secret[j]) begin
                     if (i == j) m_bulls++;
                     else        m_cows++;
                  end
            m_len = m_bad ? 2 : 6;
            m_cnt = m_len;
         end
         e_busy = (m_cnt > 0) && (m_cnt < m_len);
      end
      #1;
      check_output("model_done", done, e_done);
      check_output("model_busy", busy, e_busy);
      check_output("model_bulls", bulls, e_bulls);
      check_output("model_cows", cows, e_cows);
      check_output("model_invalid", invalid, e_invalid);
      check_output("model_tries", tries, e_tries);
      check_output("model_win", win, e_win);
      check_output("model_lose", lose, e_lose);
   end

   // Holds the given pulses for one cycle, then randomises the guess bus.
   task automatic apply_stimulus(input bit ng, input bit st);
      new_game = ng;
      start    = st;
      @(negedge clk);
      new_game = 0;
      start    = 0;
      guess1 = 4'($urandom); guess2 = 4'($urandom);
      guess3 = 4'($urandom); guess4 = 4'($urandom);
   endtask

   task automatic begin_game(input logic [3:0] a, b, c, d);
      secret1 = a; secret2 = b; secret3 = c; secret4 = d;
      apply_stimulus(1, 0);
   endtask

   task automatic guess(input logic [3:0] a, b, c, d);
      guess1 = a; guess2 = b; guess3 = c; guess4 = d;
      apply_stimulus(0, 1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      check_output("reset_busy", busy, 0);
      check_output("reset_tries", tries, 0);

      // No secret yet: start is ignored.
      guess(1, 2, 3, 4);
      repeat (6) @(negedge clk);
      check_output("nosecret_busy", busy, 0);
      check_output("nosecret_done", done, 0);

      // Exact match wins; later starts are ignored.
      begin_game(1, 2, 3, 4);
      guess(1, 2, 3, 4);
      repeat (6) @(negedge clk);
      check_output("win_done", done, 1);
      check_output("win_bulls", bulls, 4);
      check_output("win_cows", cows, 0);
      check_output("win_flag", win, 1);
      check_output("win_tries", tries, 1);
      guess(1, 2, 3, 4);
      repeat (6) @(negedge clk);
      check_output("won_ignores_done", done, 0);
      check_output("won_ignores_tries", tries, 1);

      // Permutation and partial match.
      begin_game(1, 2, 3, 4);
      guess(4, 3, 2, 1);
      repeat (6) @(negedge clk);
      check_output("perm_bulls", bulls, 0);
      check_output("perm_cows", cows, 4);
      check_output("perm_tries", tries, 1);
      guess(1, 3, 5, 7);
      repeat (6) @(negedge clk);
      check_output("part_bulls", bulls, 1);
      check_output("part_cows", cows, 1);
      check_output("part_tries", tries, 2);

      // Invalid guesses report after two cycles without counting.
      begin_game(1, 2, 3, 4);
      guess(1, 4'hF, 2, 3);
      repeat (2) @(negedge clk);
      check_output("unset_done", done, 1);
      check_output("unset_invalid", invalid, 1);
      check_output("unset_bulls", bulls, 0);
      check_output("unset_tries", tries, 0);
      guess(1, 1, 2, 3);
      repeat (2) @(negedge clk);
      check_output("dup_done", done, 1);
      check_output("dup_invalid", invalid, 1);
      check_output("dup_cows", cows, 0);
      check_output("dup_tries", tries, 0);

      // Running out of attempts.
      begin_game(1, 2, 3, 4);
      for (int k = 0; k < MAX_TRIES; k++) begin
         guess(5, 6, 7, 8);
         repeat (6) @(negedge clk);
      end
      check_output("lose_flag", lose, 1);
      check_output("lose_tries", tries, MAX_TRIES);
      check_output("lose_win", win, 0);
      guess(5, 6, 7, 8);
      repeat (6) @(negedge clk);
      check_output("lost_ignores_done", done, 0);

      // new_game during the third scan cycle aborts the scan.
      begin_game(1, 2, 3, 4);
      guess(4, 3, 2, 1);
      repeat (3) @(negedge clk);
      begin_game(1, 2, 3, 4);
      check_output("abort_busy", busy, 0);
      check_output("abort_tries", tries, 0);
      repeat (4) @(negedge clk);
      check_output("abort_no_done", done, 0);
      guess(1, 2, 4, 3);
      repeat (6) @(negedge clk);
      check_output("after_abort_bulls", bulls, 2);
      check_output("after_abort_cows", cows, 2);
      check_output("after_abort_tries", tries, 1);

      // new_game and start together: only the new game takes effect.
      secret1 = 2; secret2 = 3; secret3 = 4; secret4 = 5;
      guess1 = 2; guess2 = 3; guess3 = 4; guess4 = 5;
      apply_stimulus(1, 1);
      repeat (6) @(negedge clk);
      check_output("both_no_done", done, 0);
      check_output("both_busy", busy, 0);
      check_output("both_tries", tries, 0);
      guess(2, 3, 4, 5);
      repeat (6) @(negedge clk);
      check_output("both_then_win", win, 1);

      // Asynchronous reset in the middle of a scan.
      begin_game(0, 1, 2, 3);
      guess(0, 1, 3, 2);
      repeat (6) @(negedge clk);
      guess(3, 2, 1, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 0;
      #1;
      check_output("areset_busy", busy, 0);
      check_output("areset_tries", tries, 0);
      check_output("areset_cows", cows, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      // Random play over a small digit alphabet so wins and losses occur.
      for (int cyc = 0; cyc < 1500; cyc++) begin
         secret1 = 4'($urandom_range(0, 5)); secret2 = 4'($urandom_range(0, 5));
         secret3 = 4'($urandom_range(0, 5)); secret4 = 4'($urandom_range(0, 5));
         guess1 = ($urandom % 12 == 0) ? 4'hF : 4'($urandom_range(0, 5));
         guess2 = 4'($urandom_range(0, 5));
         guess3 = 4'($urandom_range(0, 5));
         guess4 = 4'($urandom_range(0, 5));
         new_game = ($urandom % 40 == 0);
         start    = ($urandom % 3 == 0);
         @(negedge clk);
      end
      new_game = 0;
      start    = 0;
      repeat (10) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bc_judge.md
# bc_judge

Scoring stage for the Bulls-and-Cows game. It sits directly downstream of the four-digit input collector and consumes its four registered 4-bit digit outputs as the guess. On a start pulse it validates the guess, scores it against a latched secret over a fixed multi-cycle scan, and reports bulls/cows. It also tracks attempts and the win/lose outcome.

## Interface
- MAX_TRIES, default 10: attempts allowed per game, range 1..15.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- new_game  in  1  pulse; latches secret1..4, clears the score/attempt state, aborts any scan in progress.
- secret1..secret4  in  4 each  secret digits, sampled only on new_game.
- start  in  1  pulse; requests scoring of guess1..4.
- guess1..guess4  in  4 each  guess digits, driven by the collector's out1..out4.
- busy  out  1  high from the cycle after start is accepted until REPORT inclusive.
- done  out  1  one-cycle pulse; the result is valid.
- bulls  out  3  count of correct digits in the correct position, 0..4.
- cows  out  3  count of correct digits in the wrong position, 0..4.
- invalid  out  1  the last guess was rejected.
- tries  out  4  number of valid guesses scored in this game.
- win  out  1  sticky until new_game.
- lose  out  1  sticky until new_game.

## Operation
- States are NOSECRET, IDLE, VALIDATE, SCAN, REPORT, WON and LOST.
- Reset puts the block in NOSECRET with every output 0.
- new_game, from any state, checks the secret digits.
  - If the secret digits are all ≤9 and pairwise distinct: latch them, clear tries, win, lose, bulls, cows and invalid, and go to IDLE.
  - Otherwise: go to NOSECRET with the same clears.
- new_game has priority over start in the same cycle; the start is dropped.
- start is accepted only in IDLE. It is ignored in every other state, with no queueing.
  - On acceptance, snapshot guess1..4 into internal registers and go to VALIDATE.
- VALIDATE takes 1 cycle.
  - The guess is invalid if any digit is >9 (including the collector's 4'hF reset value) or any two digits are equal.
  - Invalid: go to REPORT with invalid=1; tries is unchanged.
  - Valid: clear the accumulators, set idx=0, go to SCAN.
- SCAN takes 4 cycles, idx 0..3.
  - Each cycle, bulls_acc += (g[idx]==s[idx]) and cows_acc += count over j≠idx of (g[idx]==s[j]).
  - At idx=3, go to REPORT.
- REPORT takes 1 cycle.
  - done=1; bulls and cows are loaded from the accumulators (both 0 if invalid); invalid is updated.
  - If the guess was valid, tries+1.
  - If bulls==4: win=1, go to WON.
  - Else if the new tries==MAX_TRIES: lose=1, go to LOST.
  - Otherwise go to IDLE.
- bulls, cows and invalid hold their values until the next REPORT or new_game.
- The accumulators are 3 bits wide. bulls+cows ≤4 always holds, and no overflow is possible.

## Timing
- start is sampled high at edge N.
- Valid guess: done is high in the cycle after edge N+6, i.e. VALIDATE at N+1, SCAN at N+2..N+5, REPORT at N+6.
- Invalid guess: done is high after edge N+2.
- busy rises after edge N+1 and falls after the edge that leaves REPORT.
- A new start may be sampled in the first IDLE cycle after REPORT.
- Guess inputs may change freely after edge N; the snapshot decouples them.
- new_game during VALIDATE, SCAN or REPORT aborts:
  - no done pulse;
  - busy drops after that edge;
  - tries is not incremented.
- An rst_n assertion mid-scan forces NOSECRET immediately and asynchronously, with all outputs 0.

## Structure
- Package bc_pkg holds:
  - NUM_DIGITS=4, DIGIT_W=4, MAX_DIGIT=9, DIGIT_UNSET=4'hF;
  - the state enum;
  - a digit array typedef shared with the collector.
- One combinational sub-module, bc_digit_match.
  - Inputs: one guess digit, the four secret digits, and idx.
  - Outputs: a bull bit and a 2-bit cow count.
  - Instantiate it once and time-multiplex it across the SCAN cycles.

## Test plan
- new_game with secret 1,2,3,4, then guess 1,2,3,4 and start -> done 6 cycles later; bulls=4, cows=0, win=1, tries=1; further starts ignored.
- Secret 1,2,3,4, guess 4,3,2,1 -> bulls=0, cows=4, tries=1. Guess 1,3,5,7 -> bulls=1, cows=1, tries=2.
- Guess 1,F,2,3 (collector reset value), then guess 1,1,2,3 -> both give done 2 cycles after start with invalid=1 and bulls=cows=0; tries is unchanged at 0.
- With MAX_TRIES=10, ten valid non-winning guesses (5,6,7,8 each) -> after the 10th, lose=1 and tries=10; an 11th start produces no done.
- new_game asserted during the 3rd SCAN cycle -> no done; busy drops next cycle; tries=0; a subsequent guess scores normally.
- start and new_game in the same cycle -> new_game takes effect and no scan starts. start before any new_game since reset -> ignored; busy stays 0.
